line_fifo_reader: RTL and testbench

- Read-side controller for the ping-pong line buffer that sits between the ADC capture path and the frame output path.
- On each completed line it swaps banks, so the writer fills the other bank.
- It then reads the filled bank pixel by pixel through a synchronous read port, with 1-cycle latency.
- Pixels go out as a valid/ready stream with line-start and line-end markers, at full throughput when the sink never stalls.

---
 rtl/line_fifo_reader_if.sv | 38 +++
 rtl/line_fifo_reader.sv | 161 ++++++++++++++++
 tb/tb_line_fifo_reader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fifo_reader_if.sv
`default_nettype none
// ============================================================================
// line_fifo_reader_if - RAM read port, line trigger and pixel stream bundle
// Rev 1.0
// ============================================================================
interface line_fifo_reader_if #(
  parameter int ADC_WIDHT = 14,
  parameter int ADDR_W    = 8
) ();
  logic                 i_line_ready;
  logic                 o_bank_sel;
  logic                 o_rd_en;
  logic [ADDR_W-1:0]    o_rd_addr;
  logic [ADC_WIDHT-1:0] i_rd_data;
  logic [ADC_WIDHT-1:0] o_data_out;
  logic                 o_data_valid;
  logic                 i_data_ready;
  logic                 o_line_start;
  logic                 o_line_end;
  logic                 o_busy;
  logic                 o_overrun;
  logic                 i_overrun_clr;

  // The reader side.
  modport master (
    input  i_line_ready, i_rd_data, i_data_ready, i_overrun_clr,
    output o_bank_sel, o_rd_en, o_rd_addr, o_data_out, o_data_valid,
           o_line_start, o_line_end, o_busy, o_overrun
  );

  // The writer / RAM / sink side.
  modport slave (
    output i_line_ready, i_rd_data, i_data_ready, i_overrun_clr,
    input  o_bank_sel, o_rd_en, o_rd_addr, o_data_out, o_data_valid,
           o_line_start, o_line_end, o_busy, o_overrun
  );
endinterface
`default_nettype wire

// File: rtl/line_fifo_reader.sv
`default_nettype none
// ============================================================================
// line_fifo_reader - swaps ping-pong banks per line and streams the line out
// Rev 1.0
// ============================================================================
module line_fifo_reader #(
  parameter int ADC_WIDHT  = 14,
  parameter int PIX_IN_ROW = 160,
  parameter int ADDR_W     = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  line_fifo_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(PIX_IN_ROW - 1);
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_bank_sel;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic                  r_pend;
  logic [ADDR_W-1:0]     r_pend_addr;
  logic [ADC_WIDHT-1:0]  r_data;
  logic                  r_valid;
  logic                  r_start;
  logic                  r_end;
  logic [ADC_WIDHT-1:0]  r_skid_data;
  logic                  r_skid_full;
  logic                  r_skid_start;
  logic                  r_skid_end;
  logic                  r_overrun;

  logic                  w_accept;
  logic                  w_busy;
  logic                  w_issue;
  logic                  w_line_go;
  logic                  w_ret_start;
  logic                  w_ret_end;

  assign w_accept    = r_valid & bus.i_data_ready;
  assign w_busy      = (r_state != S_IDLE);
  assign w_ret_start = (r_pend_addr == '0);
  assign w_ret_end   = (r_pend_addr == c_last_addr);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_line_go   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_line_ready) begin
          w_line_go   = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      // The read count is bounded by leaving READ right after the last address.
      S_READ: begin
        w_issue = (!r_valid || bus.i_data_ready) && !r_skid_full;
        if (w_issue && (r_rd_addr == c_last_addr)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_accept && r_end && !r_skid_full) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bank_sel  <= 1'b0;
      r_rd_addr   <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_issue;
      if (w_line_go) begin
        r_bank_sel <= ~r_bank_sel;
        r_rd_addr  <= '0;
      end else if (w_issue && (r_rd_addr != c_last_addr)) begin
        r_rd_addr <= r_rd_addr + c_addr_one;
      end
      if (w_issue) begin
        r_pend_addr <= r_rd_addr;
      end
    end
  end

  // Returning data can never meet a full skid: an issue needs an empty skid
  // and a free (or draining) output register in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_start      <= 1'b0;
      r_end        <= 1'b0;
      r_skid_data  <= '0;
      r_skid_full  <= 1'b0;
      r_skid_start <= 1'b0;
      r_skid_end   <= 1'b0;
    end else if (r_pend) begin
      if (!r_valid || w_accept) begin
        r_data  <= bus.i_rd_data;
        r_start <= w_ret_start;
        r_end   <= w_ret_end;
        r_valid <= 1'b1;
      end else begin
        r_skid_data  <= bus.i_rd_data;
        r_skid_start <= w_ret_start;
        r_skid_end   <= w_ret_end;
        r_skid_full  <= 1'b1;
      end
    end else if (w_accept) begin
      if (r_skid_full) begin
        r_data      <= r_skid_data;
        r_start     <= r_skid_start;
        r_end       <= r_skid_end;
        r_valid     <= 1'b1;
        r_skid_full <= 1'b0;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // A pulse while busy, including the cycle DRAIN hands back to IDLE, is an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (bus.i_line_ready && w_busy) begin
      r_overrun <= 1'b1;
    end else if (bus.i_overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.o_bank_sel   = r_bank_sel;
  assign bus.o_rd_en      = w_issue;
  assign bus.o_rd_addr    = r_rd_addr;
  assign bus.o_data_out   = r_data;
  assign bus.o_data_valid = r_valid;
  assign bus.o_line_start = r_valid & r_start;
  assign bus.o_line_end   = r_valid & r_end;
  assign bus.o_busy       = w_busy;
  assign bus.o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_line_fifo_reader.sv
`default_nettype none
// ============================================================================
// tb_line_fifo_reader - line table plus corner sequences, scoreboarded stream
// Rev 1.0
// ============================================================================
module tb_line_fifo_reader;

  localparam int W  = 14;
  localparam int N  = 160;
  localparam int AW = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         s;
    logic         e;
  } px_t;

  typedef struct {
    logic [3:0] pat;      // DATA_READY pattern, bit k%4 in cycle k
    int         dup_at;   // accepted-pixel count at which to re-pulse, -1 none
    bit         dup_clr;  // drive OVERRUN_CLR together with the re-pulse
    bit         do_clr;   // clear OVERRUN after the line
    bit         exp_bank;
    bit         exp_ovr;
  } row_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  line_fifo_reader_if #(.ADC_WIDHT(W), .ADDR_W(AW)) bus ();

  line_fifo_reader #(.ADC_WIDHT(W), .PIX_IN_ROW(N), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] mem0 [0:255];
  logic [W-1:0] mem1 [0:255];

  always @(posedge clk) begin
    if (bus.o_rd_en) begin
      bus.i_rd_data <= bus.o_bank_sel ? mem1[bus.o_rd_addr] : mem0[bus.o_rd_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle on the falling edge.
  px_t  q[$];
  bit   m_bank, m_busy, m_ovr, m_hold, m_prev_rden, m_wait_first, old_busy, acc;
  px_t  m_hold_px, m_pop, m_px;
  int   m_inflight, m_issued, m_accepted, m_lat, m_valid_cycles;
  int   m_first_cyc, m_end_cyc, mcyc, holding;

  always @(negedge clk) begin
    mcyc++;
    if (!rst_n) begin
      q.delete();
      m_bank = 0; m_busy = 0; m_ovr = 0; m_hold = 0; m_prev_rden = 0;
      m_wait_first = 0; m_inflight = 0; m_issued = 0; m_accepted = 0;
      m_lat = 0; m_valid_cycles = 0;
    end else begin
      old_busy = m_busy;
      acc = bus.o_data_valid && bus.i_data_ready;
      check("bank_sel", bus.o_bank_sel, m_bank);
      check("busy", bus.o_busy, m_busy);
      check("overrun", bus.o_overrun, m_ovr);
      if (m_hold) begin
        check("stall_valid", bus.o_data_valid, 1);
        check("stall_data", bus.o_data_out, m_hold_px.d);
        check("stall_start", bus.o_line_start, m_hold_px.s);
        check("stall_end", bus.o_line_end, m_hold_px.e);
      end
      if (bus.o_rd_en) begin
        holding = m_inflight - (m_prev_rden ? 1 : 0);
        check("rd_addr_seq", bus.o_rd_addr, m_issued);
        check("rd_addr_max", bus.o_rd_addr <= AW'(N - 1), 1);
        check("rd_gate", (holding == 0) || (holding == 1 && acc), 1);
        m_issued++;
        m_inflight++;
      end
      if (m_wait_first) begin
        m_lat++;
        if (bus.o_data_valid) begin
          // Valid appears on the second edge after the one capturing LINE_READY.
          check("first_latency", m_lat, 3);
          m_wait_first = 0;
          m_first_cyc = mcyc;
        end
      end
      if (bus.o_data_valid) m_valid_cycles++;
      if (acc) begin
        check("px_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          m_pop = q.pop_front();
          check("px_data", bus.o_data_out, m_pop.d);
          check("px_start", bus.o_line_start, m_pop.s);
          check("px_end", bus.o_line_end, m_pop.e);
          m_accepted++;
          m_inflight--;
          if (m_pop.e) begin
            m_busy = 0;
            m_end_cyc = mcyc;
          end
        end
      end
      m_hold = bus.o_data_valid && !bus.i_data_ready;
      m_hold_px = '{d: bus.o_data_out, s: bus.o_line_start, e: bus.o_line_end};
      m_prev_rden = bus.o_rd_en;
      if (bus.i_line_ready && old_busy) m_ovr = 1;
      else if (bus.i_overrun_clr) m_ovr = 0;
      if (bus.i_line_ready && !old_busy) begin
        m_bank = ~m_bank;
        m_busy = 1;
        m_issued = 0; m_accepted = 0; m_valid_cycles = 0;
        m_wait_first = 1; m_lat = 0;
        for (int i = 0; i < N; i++) begin
          m_px.d = (m_bank ? W'('h100) : W'('h2000)) + W'(i);
          m_px.s = (i == 0);
          m_px.e = (i == N - 1);
          q.push_back(m_px);
        end
      end
    end
  end

  task automatic run_line(input logic [3:0] pat, input int dup_at, input bit dup_clr);
    int  k;
    bit  dup_done;
    bit  ok;
    @(posedge clk); #1;
    bus.i_line_ready = 1'b1;
    bus.i_data_ready = pat[0];
    @(posedge clk); #1;
    bus.i_line_ready = 1'b0;
    k = 1; dup_done = 0; ok = 0;
    for (int t = 0; t < 3000; t++) begin
      bus.i_data_ready  = pat[k % 4];
      k++;
      bus.i_line_ready  = 1'b0;
      bus.i_overrun_clr = 1'b0;
      if (!dup_done && dup_at >= 0 && m_accepted == dup_at) begin
        bus.i_line_ready  = 1'b1;
        bus.i_overrun_clr = dup_clr;
        dup_done = 1;
      end
      @(posedge clk); #1;
      if (!m_busy && !bus.o_busy) begin
        ok = 1;
        break;
      end
    end
    bus.i_line_ready  = 1'b0;
    bus.i_overrun_clr = 1'b0;
    bus.i_data_ready  = 1'b1;
    check("line_done_in_time", ok, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_bank_sel", bus.o_bank_sel, 0);
    check("rst_rd_en", bus.o_rd_en, 0);
    check("rst_rd_addr", bus.o_rd_addr, 0);
    check("rst_data_out", bus.o_data_out, 0);
    check("rst_data_valid", bus.o_data_valid, 0);
    check("rst_line_start", bus.o_line_start, 0);
    check("rst_line_end", bus.o_line_end, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_overrun", bus.o_overrun, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows [4];
    bit   ok;

    rows[0] = '{pat: 4'b1111, dup_at: -1, dup_clr: 0, do_clr: 0, exp_bank: 1, exp_ovr: 0};
    rows[1] = '{pat: 4'b1001, dup_at: -1, dup_clr: 0, do_clr: 0, exp_bank: 0, exp_ovr: 0};
    rows[2] = '{pat: 4'b1111, dup_at: 50, dup_clr: 1, do_clr: 1, exp_bank: 1, exp_ovr: 1};
    rows[3] = '{pat: 4'b0110, dup_at: -1, dup_clr: 0, do_clr: 0, exp_bank: 0, exp_ovr: 0};

    n_tests = 0; n_fail = 0; mcyc = 0;
    for (int a = 0; a < 256; a++) begin
      mem0[a] = W'('h2000) + W'(a);
      mem1[a] = W'('h100) + W'(a);
    end
    rst_n = 1'b0;
    bus.i_line_ready  = 1'b0;
    bus.i_data_ready  = 1'b1;
    bus.i_overrun_clr = 1'b0;
    bus.i_rd_data     = '0;
    idle(3);
    check_reset_outputs();
    rst_n = 1'b1;
    idle(3);

    for (int r = 0; r < 4; r++) begin
      run_line(rows[r].pat, rows[r].dup_at, rows[r].dup_clr);
      check("line_px_count", m_accepted, N);
      check("line_queue_empty", q.size(), 0);
      check("line_bank_sel", bus.o_bank_sel, rows[r].exp_bank);
      check("line_overrun", bus.o_overrun, rows[r].exp_ovr);
      if (rows[r].pat == 4'b1111) begin
        check("line_valid_cycles", m_valid_cycles, N);
        check("line_valid_span", m_end_cyc - m_first_cyc + 1, N);
      end
      if (rows[r].do_clr) begin
        bus.i_overrun_clr = 1'b1;
        @(posedge clk); #1;
        bus.i_overrun_clr = 1'b0;
        check("overrun_cleared", bus.o_overrun, 0);
      end
      idle(5);
    end

    // Reset in the middle of a line, then a clean line afterwards.
    @(posedge clk); #1;
    bus.i_line_ready = 1'b1;
    bus.i_data_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_line_ready = 1'b0;
    ok = 0;
    for (int t = 0; t < 400; t++) begin
      if (m_accepted >= 80 && bus.o_data_valid) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reach_pixel_80", ok, 1);
    check("pre_reset_bank", bus.o_bank_sel, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    idle(2);
    rst_n = 1'b1;
    idle(3);
    run_line(4'b1111, -1, 0);
    check("post_reset_px_count", m_accepted, N);
    check("post_reset_bank", bus.o_bank_sel, 1);
    idle(4);

    // LINE_READY in the cycle the final pixel is accepted.
    @(posedge clk); #1;
    bus.i_line_ready = 1'b1;
    bus.i_data_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_line_ready = 1'b0;
    ok = 0;
    for (int t = 0; t < 400; t++) begin
      if (bus.o_data_valid && bus.o_line_end) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reach_line_end", ok, 1);
    bus.i_line_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_line_ready = 1'b0;
    idle(4);
    check("late_pulse_overrun", bus.o_overrun, 1);
    check("late_pulse_busy", bus.o_busy, 0);
    check("late_pulse_bank", bus.o_bank_sel, 0);
    check("late_pulse_no_valid", bus.o_data_valid, 0);
    check("late_pulse_px_count", m_accepted, N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
